logicunit_serializer: RTL and testbench



---
 rtl/logicunit_serializer.sv | 122 ++++++++++++
 tb/tb_logicunit_serializer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/logicunit_serializer.sv
// Bit-serial wrapper around a 1-bit logic unit (0 AND, 1 OR, 2 NOR, 3 XOR), LSB first.
// Optional zero flag output enabled by defining LOGICSER_ZERO_FLAG_EN.
module logicunit_serializer #(
    parameter int unsigned W = 32
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [1:0]   control,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out
`ifdef LOGICSER_ZERO_FLAG_EN
    ,
    output logic         zero
`endif
);

    localparam int unsigned CntW = $clog2(W);
    localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    sa_q, sa_d;
    logic [W-1:0]    sb_q, sb_d;
    logic [W-1:0]    res_q, res_d;
    logic [1:0]      op_q, op_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            lu_out;

    // Single-bit logic unit evaluated on the current LSBs.
    always_comb begin
        lu_out = 1'b0;
        unique case (op_q)
            2'd0: lu_out = sa_q[0] & sb_q[0];
            2'd1: lu_out = sa_q[0] | sb_q[0];
            2'd2: lu_out = ~(sa_q[0] | sb_q[0]);
            2'd3: lu_out = sa_q[0] ^ sb_q[0];
            default: lu_out = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sa_d    = A;
                    sb_d    = B;
                    op_d    = control;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                res_d = {lu_out, res_q[W-1:1]};
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                // Hold the counter on the final bit so it never wraps.
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            op_q    <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign out       = res_q;

`ifdef LOGICSER_ZERO_FLAG_EN
    logic zero_q;

    // Tracks res exactly, so it is 1 at reset and after the clear at accept.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            zero_q <= 1'b1;
        end else begin
            zero_q <= (res_d == '0);
        end
    end

    assign zero = zero_q;
`endif

endmodule

// File: tb/tb_logicunit_serializer.sv
// Directed self-checking bench for logicunit_serializer (W=8 and W=32 instances).
module tb_logicunit_serializer;

    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(input string tag, input bit ok, input logic [63:0] obs,
                                input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endfunction

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic        v8 = 1'b0, rdy8, ov8, ordy8 = 1'b1;
    logic [7:0]  a8 = '0, b8 = '0, o8;
    logic [1:0]  c8 = '0;
    logic        v32 = 1'b0, rdy32, ov32, ordy32 = 1'b1;
    logic [31:0] a32 = '0, b32 = '0, o32;
    logic [1:0]  c32 = '0;
`ifdef LOGICSER_ZERO_FLAG_EN
    logic z8, z32;
`endif

    logicunit_serializer #(.W(8)) dut8 (
        .clock(clock), .reset_n(reset_n), .in_valid(v8), .in_ready(rdy8),
        .A(a8), .B(b8), .control(c8), .out_valid(ov8), .out_ready(ordy8), .out(o8)
`ifdef LOGICSER_ZERO_FLAG_EN
        , .zero(z8)
`endif
    );

    logicunit_serializer #(.W(32)) dut32 (
        .clock(clock), .reset_n(reset_n), .in_valid(v32), .in_ready(rdy32),
        .A(a32), .B(b32), .control(c32), .out_valid(ov32), .out_ready(ordy32), .out(o32)
`ifdef LOGICSER_ZERO_FLAG_EN
        , .zero(z32)
`endif
    );

    function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] c);
        case (c)
            2'd0: return a & b;
            2'd1: return a | b;
            2'd2: return ~(a | b);
            default: return a ^ b;
        endcase
    endfunction

    // Issue one W=8 op from IDLE and wait for out_valid; checks latency and result.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] c,
                       input logic [7:0] exp, input string tag);
        int n;
        @(posedge clock); #1;
        chk({tag, " ready"}, rdy8 === 1'b1, rdy8, 1'b1);
        a8 = a; b8 = b; c8 = c; v8 = 1'b1;
        @(posedge clock); #1;
        v8 = 1'b0;
        n = 0;
        while (!ov8 && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        chk({tag, " latency"}, n === 8, n, 8);
        chk({tag, " out"}, o8 === exp, o8, exp);
    endtask

    // Handshake with out_ready=1 is on the next edge; IDLE right after it.
    task automatic finish8(input string tag);
        @(posedge clock); #1;
        chk({tag, " ov_low"}, ov8 === 1'b0, ov8, 1'b0);
        chk({tag, " ready_back"}, rdy8 === 1'b1, rdy8, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, ec, prev;
        logic [31:0] ea, eb, eo;
        logic [1:0]  ecc;

        // Reset state
        #12;
        chk("rst in_ready", rdy8 === 1'b1, rdy8, 1'b1);
        chk("rst out_valid", ov8 === 1'b0, ov8, 1'b0);
        chk("rst out", o8 === 8'h00, o8, 8'h00);
`ifdef LOGICSER_ZERO_FLAG_EN
        chk("rst zero", z8 === 1'b1, z8, 1'b1);
`endif
        #5 reset_n = 1'b1;

        // All four ops on F0/CC with out_ready held high
        op8(8'hF0, 8'hCC, 2'd0, 8'hC0, "and");
`ifdef LOGICSER_ZERO_FLAG_EN
        chk("and zero", z8 === 1'b0, z8, 1'b0);
`endif
        finish8("and");
        op8(8'hF0, 8'hCC, 2'd1, 8'hFC, "or");
        finish8("or");
        op8(8'hF0, 8'hCC, 2'd2, 8'h03, "nor");
        finish8("nor");
        op8(8'hF0, 8'hCC, 2'd3, 8'h3C, "xor");
        finish8("xor");

        // Back-pressure: zero result held while stalled; in_valid in DONE ignored
        ordy8 = 1'b0;
        op8(8'hAA, 8'h55, 2'd0, 8'h00, "stall");
        v8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            chk("stall ov", ov8 === 1'b1, ov8, 1'b1);
            chk("stall out", o8 === 8'h00, o8, 8'h00);
            chk("stall in_ready", rdy8 === 1'b0, rdy8, 1'b0);
`ifdef LOGICSER_ZERO_FLAG_EN
            chk("stall zero", z8 === 1'b1, z8, 1'b1);
`endif
        end
        ordy8 = 1'b1;
        @(posedge clock); #1;
        v8 = 1'b0;
        chk("stall release ov", ov8 === 1'b0, ov8, 1'b0);
        chk("stall no_accept", rdy8 === 1'b1, rdy8, 1'b1);

        // Input changes and in_valid pulses during SHIFT are ignored
        @(posedge clock); #1;
        a8 = 8'h0F; b8 = 8'hFF; c8 = 2'd3; v8 = 1'b1;
        @(posedge clock); #1;
        a8 = 8'h33; b8 = 8'h77; c8 = 2'd0;
        v8 = 1'b0;
        n = 0;
        while (!ov8 && n < 20) begin
            @(posedge clock); #1;
            n++;
            v8 = (n == 2 || n == 3);
            if (n == 3) chk("shift in_ready", rdy8 === 1'b0, rdy8, 1'b0);
        end
        v8 = 1'b0;
        chk("ignore latency", n === 8, n, 8);
        chk("ignore out", o8 === 8'hF0, o8, 8'hF0);
        finish8("ignore");

        // Asynchronous reset in the middle of SHIFT
        @(posedge clock); #1;
        a8 = 8'h0F; b8 = 8'hFF; c8 = 2'd3; v8 = 1'b1;
        @(posedge clock); #1;
        v8 = 1'b0;
        repeat (3) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst in_ready", rdy8 === 1'b1, rdy8, 1'b1);
        chk("midrst ov", ov8 === 1'b0, ov8, 1'b0);
        #10 reset_n = 1'b1;
        repeat (10) begin
            @(posedge clock); #1;
            if (ov8) break;
        end
        chk("midrst no_result", ov8 === 1'b0, ov8, 1'b0);
        op8(8'h81, 8'h18, 2'd1, 8'h99, "after_rst");
        finish8("after_rst");

        // W=32 back-to-back random ops; accepts must be W+2 edges apart
        ec = 0; prev = 0;
        a32 = $urandom; b32 = $urandom; c32 = 2'($urandom_range(0, 3));
        v32 = 1'b1; ordy32 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            while (!rdy32 && n < 100) begin
                @(posedge clock); #1;
                ec++; n++;
            end
            ea = a32; eb = b32; ecc = c32;
            @(posedge clock); #1;
            ec++;
            if (k > 0) chk("w32 interval", (ec - prev) === 34, ec - prev, 34);
            prev = ec;
            a32 = $urandom; b32 = $urandom; c32 = 2'($urandom_range(0, 3));
            n = 0;
            while (!ov32 && n < 100) begin
                @(posedge clock); #1;
                ec++; n++;
            end
            eo = ref_op(ea, eb, ecc);
            chk("w32 latency", n === 32, n, 32);
            chk("w32 out", o32 === eo, o32, eo);
        end
        v32 = 1'b0;
        @(posedge clock); #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
